// File: rtl/fence_ctrl_if.sv
// rtl/fence_ctrl_if.sv - dispatch-side bundle for the fence controller
interface fence_ctrl_if #(
   parameter int LU_DEPTH = 4,
   parameter int CNT_W    = 8
);
   logic                flush;
   logic                fence_req;
   logic                fence_is_i;
   logic [3:0]          fence_pred;
   logic                su_fifo_empty;
   logic [LU_DEPTH-1:0] lu_buffer_malloc;
   logic                rob_empty;
   logic                icache_inv_ack;
   logic                icache_inv_req;
   logic                fence_ack;
   logic                dispat_stall;
   logic                fence_busy;
   logic [CNT_W-1:0]    drain_cycles;

   modport master (
      output flush, fence_req, fence_is_i, fence_pred, su_fifo_empty,
             lu_buffer_malloc, rob_empty, icache_inv_ack,
      input  icache_inv_req, fence_ack, dispat_stall, fence_busy, drain_cycles
   );

   modport slave (
      input  flush, fence_req, fence_is_i, fence_pred, su_fifo_empty,
             lu_buffer_malloc, rob_empty, icache_inv_ack,
      output icache_inv_req, fence_ack, dispat_stall, fence_busy, drain_cycles
   );
endinterface

// File: rtl/fence_ctrl.sv
// rtl/fence_ctrl.sv - FENCE / FENCE.I serialiser holding dispatch until memory drains
// FENCE.I also waits for an empty ROB and completes an icache invalidate handshake.
module fence_ctrl #(
   parameter int LU_DEPTH = 4,
   parameter int CNT_W    = 8
) (
   input  logic          i_clk,
   input  logic          i_rst,
   fence_ctrl_if.slave   bus
);
   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_DRAIN     = 3'd1,
      S_INV       = 3'd2,
      S_INV_ABORT = 3'd3,
      S_DONE      = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t              r_state;
   state_t              w_next;
   logic                r_is_i;
   logic                r_need_s;
   logic                r_need_l;
   logic [CNT_W-1:0]    r_drain_cnt;
   logic [LU_DEPTH-1:0] w_lu_occ;
   logic                w_drained;
   logic                w_start;

   assign w_lu_occ  = bus.lu_buffer_malloc;
   assign w_drained = (~r_need_s | bus.su_fifo_empty) &
                      (~r_need_l | ~|w_lu_occ) &
                      (~r_is_i   | bus.rob_empty);
   assign w_start   = (r_state == S_IDLE) & bus.fence_req & ~bus.flush;

   // Fence attributes are captured once on entry; the inputs are ignored afterwards.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_is_i      <= 1'b0;
         r_need_s    <= 1'b0;
         r_need_l    <= 1'b0;
         r_drain_cnt <= '0;
      end else begin
         r_state <= w_next;
         if (w_start) begin
            r_is_i      <= bus.fence_is_i;
            r_need_s    <= bus.fence_pred[2] | bus.fence_pred[0] | bus.fence_is_i;
            r_need_l    <= bus.fence_pred[3] | bus.fence_pred[1] | bus.fence_is_i;
            r_drain_cnt <= '0;
         end else if ((r_state == S_DRAIN) && !bus.flush && !w_drained &&
                      (r_drain_cnt != CNT_MAX)) begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_start) w_next = S_DRAIN;
         end
         S_DRAIN: begin
            if (bus.flush)      w_next = S_IDLE;
            else if (w_drained) w_next = r_is_i ? S_INV : S_DONE;
         end
         // A started invalidate is never withdrawn; flush only decides where it ends.
         S_INV: begin
            if (bus.icache_inv_ack) w_next = bus.flush ? S_IDLE : S_DONE;
            else if (bus.flush)     w_next = S_INV_ABORT;
         end
         S_INV_ABORT: begin
            if (bus.icache_inv_ack) w_next = S_IDLE;
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      bus.icache_inv_req = 1'b0;
      bus.fence_busy     = 1'b0;
      bus.fence_ack      = 1'b0;
      bus.dispat_stall   = 1'b0;
      bus.drain_cycles   = r_drain_cnt;
      bus.icache_inv_req = (r_state == S_INV) | (r_state == S_INV_ABORT);
      bus.fence_busy     = (r_state != S_IDLE);
      bus.fence_ack      = (r_state == S_DONE) & ~bus.flush;
      bus.dispat_stall   = (r_state != S_IDLE) | bus.fence_req;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst && (r_state == S_DRAIN) && !bus.flush) begin
         assert (bus.fence_req);
      end
   end
endmodule
